// File: rtl/huffman_packer_pkg.sv
// Shared constants for the Huffman byte packer: table geometry, widths, FSM encodings.
// Combinational helper only; no latency, no flow control.
package huffman_packer_pkg;
    localparam int NSYM = 6;
    localparam int CW   = 8;
    localparam int ACCW = 16;
    localparam int CNTW = $clog2(ACCW + 1);
    localparam int LENW = $clog2(CW + 1);

    localparam logic [1:0] PK_IDLE  = 2'd0;
    localparam logic [1:0] PK_RUN   = 2'd1;
    localparam logic [1:0] PK_FLUSH = 2'd2;
    localparam logic [1:0] PK_DONE  = 2'd3;

    function automatic logic [LENW-1:0] popcnt(input logic [CW-1:0] v);
        logic [LENW-1:0] n;
        n = '0;
        for (int i = 0; i < CW; i++) n = n + LENW'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/huffman_packer_if.sv
// Code-table, symbol and byte-stream bundle between encoder, packer and consumer.
// Wires only; symbol and byte channels are valid/ready.
interface huffman_packer_if;
    import huffman_packer_pkg::*;

    logic            code_valid;
    logic [CW-1:0]   hc [NSYM];
    logic [CW-1:0]   m  [NSYM];
    logic            sym_valid;
    logic [7:0]      sym_data;
    logic            sym_last;
    logic            sym_ready;
    logic            out_valid;
    logic [7:0]      out_data;
    logic            out_ready;
    logic            done;
    logic [15:0]     byte_count;
    logic            sym_err;

    modport master (
        output code_valid, hc, m, sym_valid, sym_data, sym_last, out_ready,
        input  sym_ready, out_valid, out_data, done, byte_count, sym_err
    );

    modport slave (
        input  code_valid, hc, m, sym_valid, sym_data, sym_last, out_ready,
        output sym_ready, out_valid, out_data, done, byte_count, sym_err
    );
endinterface

// File: rtl/huffman_code_lut.sv
// Registered six-entry code table; symbol -> {code, len, legal} lookup is combinational.
// Loads in one cycle on load_i; no backpressure.
module huffman_code_lut
    import huffman_packer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [CW-1:0]   hc_i [NSYM],
    input  logic [CW-1:0]   m_i  [NSYM],
    input  logic [7:0]      sym_i,
    output logic [CW-1:0]   code_o,
    output logic [LENW-1:0] len_o,
    output logic            legal_o
);
    logic [CW-1:0]   code_q [NSYM];
    logic [LENW-1:0] len_q  [NSYM];

    // Codes are stored pre-masked so the datapath can OR them in directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSYM; i++) begin
                code_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else if (load_i) begin
            for (int i = 0; i < NSYM; i++) begin
                code_q[i] <= hc_i[i] & m_i[i];
                len_q[i]  <= popcnt(m_i[i]);
            end
        end
    end

    always_comb begin
        legal_o = (sym_i != 8'd0) && (sym_i <= 8'(NSYM));
        code_o  = '0;
        len_o   = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (sym_i == 8'(i + 1)) begin
                code_o = code_q[i];
                len_o  = len_q[i];
            end
        end
    end
endmodule

// File: rtl/huffman_packer.sv
// Packs Huffman codes MSB-first into bytes; a completed byte appears two cycles after its symbol.
// sym_ready drops when >=8 bits are buffered and the output byte is stalled by out_ready.
module huffman_packer
    import huffman_packer_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    huffman_packer_if.slave bus
);
    localparam logic [CNTW-1:0] C8 = CNTW'(8);

    logic [1:0]      state_q, state_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [CNTW-1:0] cnt_q, cnt_d, base;
    logic            out_vld_q, out_vld_d;
    logic [7:0]      out_dat_q, out_dat_d;
    logic [15:0]     byte_cnt_q, byte_cnt_d;
    logic            sym_err_q, sym_err_d;

    logic [CW-1:0]   code;
    logic [LENW-1:0] len;
    logic            legal;
    logic            ofree, sym_rdy, accept, take, ext_full, ext_pad;

    huffman_code_lut u_lut (
        .clk     (clk),
        .reset   (reset),
        .load_i  ((state_q == PK_IDLE) && bus.code_valid),
        .hc_i    (bus.hc),
        .m_i     (bus.m),
        .sym_i   (bus.sym_data),
        .code_o  (code),
        .len_o   (len),
        .legal_o (legal)
    );

    assign ofree    = !out_vld_q || bus.out_ready;
    assign sym_rdy  = (state_q == PK_RUN) && ((cnt_q < C8) || ofree);
    assign accept   = bus.sym_valid && sym_rdy;
    assign take     = out_vld_q && bus.out_ready;
    assign ext_full = (cnt_q >= C8) && ofree;
    assign ext_pad  = (state_q == PK_FLUSH) && (cnt_q != '0) && (cnt_q < C8) && ofree;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        byte_cnt_d = byte_cnt_q;
        sym_err_d  = sym_err_q;
        base       = cnt_q;

        // Valid bits live in acc[cnt-1:0]; anything above is stale and ignored.
        if (ext_full) begin
            out_dat_d = 8'(acc_q >> (cnt_q - C8));
            out_vld_d = 1'b1;
            base      = cnt_q - C8;
        end else if (ext_pad) begin
            out_dat_d = 8'(acc_q << (C8 - cnt_q));
            out_vld_d = 1'b1;
            base      = '0;
        end else if (take) begin
            out_vld_d = 1'b0;
        end

        cnt_d = base;
        if (accept && legal) begin
            acc_d = (acc_q << len) | ACCW'(code);
            cnt_d = base + CNTW'(len);
        end
        if (accept && !legal) sym_err_d = 1'b1;
        if (take && (byte_cnt_q != 16'hFFFF)) byte_cnt_d = byte_cnt_q + 16'd1;

        case (state_q)
            PK_IDLE: if (bus.code_valid) begin
                state_d    = PK_RUN;
                acc_d      = '0;
                cnt_d      = '0;
                byte_cnt_d = '0;
                sym_err_d  = 1'b0;
            end
            PK_RUN:   if (accept && bus.sym_last) state_d = PK_FLUSH;
            PK_FLUSH: if ((cnt_q == '0) && ofree) state_d = PK_DONE;
            default:  state_d = PK_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= PK_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            byte_cnt_q <= '0;
            sym_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            byte_cnt_q <= byte_cnt_d;
            sym_err_q  <= sym_err_d;
        end
    end

    assign bus.sym_ready  = sym_rdy;
    assign bus.out_valid  = out_vld_q;
    assign bus.out_data   = out_dat_q;
    assign bus.done       = (state_q == PK_DONE);
    assign bus.byte_count = byte_cnt_q;
    assign bus.sym_err    = sym_err_q;
endmodule
